// File: rtl/formula_pipe_result_buffer_pkg.sv
// formula_pipe_result_buffer_pkg: shared defaults and sizing helpers for the result buffer
package formula_pipe_result_buffer_pkg;

    localparam int def_width = 32;
    localparam int def_depth = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a completely full buffer is distinguishable from empty
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pipe_result_fifo.sv
// pipe_result_fifo: in-order result storage with naturally wrapping pointers and occupancy count
module pipe_result_fifo
    import formula_pipe_result_buffer_pkg::*;
#(
    parameter int width = def_width,
    parameter int depth = def_depth
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [width-1:0]          wr_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [width-1:0]          rd_data,
    output logic [cnt_w(depth)-1:0]   count
);

    localparam int pw = ptr_w(depth);
    localparam int cw = cnt_w(depth);

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    assign full    = count == cw'(depth);
    assign empty   = count == '0;
    assign wr      = push & ~full;
    assign rd      = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + pw'(wr);
            rd_ptr <= rd_ptr + pw'(rd);
            count  <= count + cw'(wr) - cw'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/formula_pipe_result_buffer.sv
// formula_pipe_result_buffer: credit-gated return buffer for non-stallable formula pipes.
// Define FORMULA_PIPE_RESULT_BUFFER_BYPASS_EN for zero-latency pass-through when empty.
module formula_pipe_result_buffer
    import formula_pipe_result_buffer_pkg::*;
#(
    parameter int width = def_width,
    parameter int depth = def_depth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    output logic             arg_vld,
    input  logic             res_vld,
    input  logic [width-1:0] res,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [width-1:0] out_data,
    output logic             err
);

    localparam int cw = cnt_w(depth);

    logic [cw-1:0]    used;
    logic [cw-1:0]    count;
    logic [width-1:0] fifo_rd;
    logic             full;
    logic             empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             bad;
    logic             take;

    assign up_rdy  = used != cw'(depth);
    assign arg_vld = up_vld & up_rdy;
    // A beat with nothing outstanding or no room is a pipe protocol error and is dropped
    assign bad     = res_vld & ((used == count) | full);
    assign take    = out_vld & out_rdy;
    assign fifo_pop = take & ~empty;

`ifdef FORMULA_PIPE_RESULT_BUFFER_BYPASS_EN
    logic byp;
    assign byp       = empty & res_vld & ~bad;
    assign out_vld   = ~empty | byp;
    assign out_data  = empty ? res : fifo_rd;
    assign fifo_push = res_vld & ~bad & ~(byp & out_rdy);
`else
    assign out_vld   = ~empty;
    assign out_data  = fifo_rd;
    assign fifo_push = res_vld & ~bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            used <= '0;
            err  <= 1'b0;
        end else begin
            used <= used + cw'(arg_vld) - cw'(take);
            err  <= err | bad;
        end
    end

    pipe_result_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (res),
        .pop     (fifo_pop),
        .full    (full),
        .empty   (empty),
        .rd_data (fifo_rd),
        .count   (count)
    );

endmodule

// File: tb/tb_formula_pipe_result_buffer.sv
// tb_formula_pipe_result_buffer: directed checks with small pipe models (depth 4/lat 3, depth 16/lat 8)
module tb_formula_pipe_result_buffer;

`ifdef FORMULA_PIPE_RESULT_BUFFER_BYPASS_EN
    localparam int lat_exp = 8;
`else
    localparam int lat_exp = 9;
`endif

    logic        clk;
    logic        rst;
    logic        clr;
    logic        up_vld_a, up_rdy_a, arg_vld_a, res_vld_a, out_vld_a, out_rdy_a, err_a;
    logic [31:0] res_a, out_data_a;
    logic        up_vld_b, up_rdy_b, arg_vld_b, res_vld_b, out_vld_b, out_rdy_b, err_b;
    logic [31:0] res_b, out_data_b;
    logic        inj;
    logic [31:0] inj_d;

    logic [2:0]  pa_v;
    logic [31:0] pa_d [3];
    int          iss_a;
    logic [7:0]  pb_v;
    logic [31:0] pb_d [8];
    int          iss_b;

    int n_cmp;
    int n_bad;

    formula_pipe_result_buffer #(.width(32), .depth(4)) u_a (
        .clk(clk), .rst(rst), .up_vld(up_vld_a), .up_rdy(up_rdy_a), .arg_vld(arg_vld_a),
        .res_vld(res_vld_a), .res(res_a), .out_vld(out_vld_a), .out_rdy(out_rdy_a),
        .out_data(out_data_a), .err(err_a)
    );

    formula_pipe_result_buffer #(.width(32), .depth(16)) u_b (
        .clk(clk), .rst(rst), .up_vld(up_vld_b), .up_rdy(up_rdy_b), .arg_vld(arg_vld_b),
        .res_vld(res_vld_b), .res(res_b), .out_vld(out_vld_b), .out_rdy(out_rdy_b),
        .out_data(out_data_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipe models keep in-flight work across DUT reset, like the real non-stallable pipes
    always_ff @(posedge clk) begin
        if (clr) begin
            pa_v  <= '0;
            pb_v  <= '0;
            iss_a <= 0;
            iss_b <= 0;
        end else begin
            pa_v  <= {pa_v[1:0], arg_vld_a};
            pb_v  <= {pb_v[6:0], arg_vld_b};
            iss_a <= iss_a + int'(arg_vld_a);
            iss_b <= iss_b + int'(arg_vld_b);
        end
        pa_d[0] <= 32'((iss_a + 1) * 10);
        pb_d[0] <= 32'((iss_b + 1) * 3);
        for (int i = 1; i < 3; i++) pa_d[i] <= pa_d[i-1];
        for (int i = 1; i < 8; i++) pb_d[i] <= pb_d[i-1];
    end

    assign res_vld_a = pa_v[2] | inj;
    assign res_a     = inj ? inj_d : pa_d[2];
    assign res_vld_b = pb_v[7];
    assign res_b     = pb_d[7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses, issued, got, cyc, first_iss, first_out, drops;
        n_cmp = 0;
        n_bad = 0;
        clr = 1'b1;
        rst = 1'b1;
        inj = 1'b0;
        inj_d = '0;
        up_vld_a = 1'b0;
        out_rdy_a = 1'b0;
        up_vld_b = 1'b0;
        out_rdy_b = 1'b0;
        step;
        step;
        clr = 1'b0;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("idle_up_rdy", 32'(up_rdy_a), 1);
            check("idle_out_vld", 32'(out_vld_a), 0);
            check("idle_err", 32'(err_a), 0);
            step;
        end

        // Fill depth-4 buffer with downstream stalled
        up_vld_a = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            pulses += int'(arg_vld_a);
            step;
        end
        check("fill_pulses", 32'(pulses), 4);
        check("fill_up_rdy", 32'(up_rdy_a), 0);
        check("fill_count", 32'(u_a.u_fifo.count), 4);
        check("fill_out_vld", 32'(out_vld_a), 1);
        check("fill_err", 32'(err_a), 0);
        up_vld_a = 1'b0;

        out_rdy_a = 1'b1;
        #1;
        check("drain_data0", out_data_a, 10);
        check("drain_up_rdy0", 32'(up_rdy_a), 0);
        step;
        for (int k = 1; k < 4; k++) begin
            check("drain_data", out_data_a, 32'((k + 1) * 10));
            check("drain_vld", 32'(out_vld_a), 1);
            check("drain_up_rdy", 32'(up_rdy_a), 1);
            step;
        end
        check("drain_empty", 32'(out_vld_a), 0);

        // Spurious result with nothing outstanding
        inj = 1'b1;
        inj_d = 32'd99;
        #1;
        check("inj_no_out", 32'(out_vld_a), 0);
        step;
        inj = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("inj_err", 32'(err_a), 1);
            check("inj_out_vld", 32'(out_vld_a), 0);
            check("inj_count", 32'(u_a.u_fifo.count), 0);
            step;
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("rst_err_clr", 32'(err_a), 0);

        // Reset with three arguments in flight
        out_rdy_a = 1'b0;
        up_vld_a = 1'b1;
        step;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        up_vld_a = 1'b0;
        #1;
        check("rst_up_rdy", 32'(up_rdy_a), 1);
        check("rst_out_vld", 32'(out_vld_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_late_arrives", 32'(res_vld_a), 1);
        step;
        for (int i = 0; i < 3; i++) begin
            check("late_err", 32'(err_a), 1);
            check("late_out_vld", 32'(out_vld_a), 0);
            step;
        end
        check("late_count", 32'(u_a.u_fifo.count), 0);

        // Streaming on the depth-16 buffer behind an 8-stage pipe
        out_rdy_b = 1'b1;
        issued = 0;
        got = 0;
        cyc = 0;
        first_iss = -1;
        first_out = -1;
        drops = 0;
        while (got < 100 && cyc < 400) begin
            up_vld_b = issued < 100;
            #1;
            if (up_vld_b && !up_rdy_b) drops++;
            if (arg_vld_b) begin
                if (first_iss < 0) first_iss = cyc;
                issued++;
            end
            if (out_vld_b) begin
                if (first_out < 0) first_out = cyc;
                check("stream_data", out_data_b, 32'((got + 1) * 3));
                got++;
            end
            step;
            cyc++;
        end
        up_vld_b = 1'b0;
        check("stream_count", 32'(got), 100);
        check("stream_stalls", 32'(drops), 0);
        check("stream_latency", 32'(first_out - first_iss), 32'(lat_exp));
        check("stream_err", 32'(err_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
